// File: rtl/irq_ctrl.sv
// irq_ctrl - machine-mode external-interrupt and WFI sequencer.
//
// Decides at an EX instruction boundary when a pending external interrupt is
// taken. It then produces a one-cycle interrupt/flush pulse with the trap PC
// for the CSR file. It tracks handler occupancy until MRET and runs the WFI
// stall/wake sequence.
//
// Optional feature: define IRQ_CTRL_SYNC_EN to pass ext_irq through a 2-flop
// synchronizer before use. When it is undefined, ext_irq must already be
// synchronous to clk.
//
// Parameters:
//   PC_W         width of PC / trap-PC
//   WFI_TIMEOUT  WFI auto-wake after this many cycles (0 = never)
//   CNT_W        width of WFI timeout counter (2^CNT_W > WFI_TIMEOUT)
//
// Ports:
//   clk          core clock
//   rst          asynchronous active-low reset
//   ext_irq      level-sensitive external interrupt request
//   meie         mie[11]
//   mstatus_mie  mstatus[3]
//   ex_valid     valid, non-stalled instruction retires from EX
//   ex_pc        PC of that instruction
//   ex_wfi       retiring instruction is WFI
//   ex_mret      retiring instruction is MRET
//   interrupt    one-cycle pulse to CSR file
//   trap_pc      PC stored into mepc, valid while interrupt=1
//   flush        kill IF/ID/EX, redirect to mtvec (with interrupt)
//   wfi_stall    freeze front end during WFI
//   in_handler   high from interrupt until MRET retires
//
// state    | meaning
// IDLE     | normal execution, watching for trap or WFI
// WFI_WAIT | stalled in WFI, waiting for wake or timeout
// TRAP     | single-cycle interrupt/flush pulse
// HANDLER  | inside handler, waiting for MRET

module irq_ctrl #(
  parameter int PC_W        = 32,
  parameter int WFI_TIMEOUT = 0,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            meie,
  input  logic            mstatus_mie,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_wfi,
  input  logic            ex_mret,
  output logic            interrupt,
  output logic [PC_W-1:0] trap_pc,
  output logic            flush,
  output logic            wfi_stall,
  output logic            in_handler
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WFI_WAIT = 2'd1,
    TRAP     = 2'd2,
    HANDLER  = 2'd3
  } state_t;

  localparam int unsigned      TO_M1    = (WFI_TIMEOUT == 0) ? 0 : WFI_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_M1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [PC_W-1:0]   wfi_pc;
  logic [CNT_W-1:0]  wfi_cnt;
  logic              irq_q;
  logic              enabled;
  logic              take;
  logic              timeout_hit;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] irq_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_sync <= 2'b00;
    end else begin
      irq_sync <= {irq_sync[0], ext_irq};
    end
  end

  assign irq_q = irq_sync[1];
`else
  assign irq_q = ext_irq;
`endif

  assign enabled     = irq_q & meie;
  assign take        = enabled & mstatus_mie;
  assign timeout_hit = (WFI_TIMEOUT != 0) && (wfi_cnt == TO_LAST);

  // All outputs are registered and updated on the same edge as the state
  // transition that implies them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wfi_pc     <= '0;
      wfi_cnt    <= '0;
      interrupt  <= 1'b0;
      trap_pc    <= '0;
      flush      <= 1'b0;
      wfi_stall  <= 1'b0;
      in_handler <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Trap wins over a same-cycle WFI; the WFI itself becomes mepc.
          if (ex_valid && take) begin
            state      <= TRAP;
            trap_pc    <= ex_pc;
            interrupt  <= 1'b1;
            flush      <= 1'b1;
            in_handler <= 1'b1;
          end else if (ex_valid && ex_wfi) begin
            state     <= WFI_WAIT;
            wfi_pc    <= ex_pc;
            wfi_cnt   <= '0;
            wfi_stall <= 1'b1;
          end
        end

        WFI_WAIT: begin
          if (wfi_cnt != CNT_MAX) begin
            wfi_cnt <= wfi_cnt + CNT_ONE;
          end
          if (take) begin
            state      <= TRAP;
            trap_pc    <= wfi_pc;
            interrupt  <= 1'b1;
            flush      <= 1'b1;
            in_handler <= 1'b1;
            wfi_stall  <= 1'b0;
          end else if (enabled || timeout_hit) begin
            // Wake without trapping: resume after the WFI.
            state     <= IDLE;
            wfi_stall <= 1'b0;
          end
        end

        TRAP: begin
          state     <= HANDLER;
          interrupt <= 1'b0;
          flush     <= 1'b0;
        end

        HANDLER: begin
          // No nesting; WFI here is a NOP.
          if (ex_valid && ex_mret) begin
            state      <= IDLE;
            in_handler <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          interrupt  <= 1'b0;
          flush      <= 1'b0;
          wfi_stall  <= 1'b0;
          in_handler <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_irq = 1'b0;
  logic        meie = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_wfi = 1'b0;
  logic        ex_mret = 1'b0;

  logic        interrupt, flush, wfi_stall, in_handler;
  logic [31:0] trap_pc;
  logic        t_interrupt, t_flush, t_wfi_stall, t_in_handler;
  logic [31:0] t_trap_pc;

  int n_chk = 0;
  int n_err = 0;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  always #5 clk = ~clk;

  irq_ctrl #(.PC_W(32), .WFI_TIMEOUT(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .meie(meie),
    .mstatus_mie(mstatus_mie), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_wfi(ex_wfi), .ex_mret(ex_mret), .interrupt(interrupt),
    .trap_pc(trap_pc), .flush(flush), .wfi_stall(wfi_stall),
    .in_handler(in_handler)
  );

  irq_ctrl #(.PC_W(32), .WFI_TIMEOUT(8), .CNT_W(16)) dut_t (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .meie(meie),
    .mstatus_mie(mstatus_mie), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_wfi(ex_wfi), .ex_mret(ex_mret), .interrupt(t_interrupt),
    .trap_pc(t_trap_pc), .flush(t_flush), .wfi_stall(t_wfi_stall),
    .in_handler(t_in_handler)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
    ex_wfi   = 1'b0;
    ex_mret  = 1'b0;
  endtask

  // After this returns, the internal pending level equals ext_irq.
  task automatic set_irq(input logic v);
    ext_irq = v;
    for (int i = 0; i < SYNC_LAT; i++) step();
  endtask

  task automatic retire(input logic [31:0] pc, input logic wfi, input logic mret);
    ex_valid = 1'b1;
    ex_pc    = pc;
    ex_wfi   = wfi;
    ex_mret  = mret;
    step();
    idle_ex();
  endtask

  initial begin
    int pulses;
    int highs;
    int lat;

    // Reset state
    step();
    step();
    chk("rst_interrupt", {31'b0, interrupt}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_wfi_stall", {31'b0, wfi_stall}, 0);
    chk("rst_in_handler", {31'b0, in_handler}, 0);
    chk("rst_trap_pc", trap_pc, 0);

    // 1: pending irq but no retiring instruction -> no trap
    ext_irq = 1'b1;
    meie = 1'b1;
    mstatus_mie = 1'b1;
    rst = 1'b1;
    set_irq(1'b1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (interrupt) pulses++;
    end
    chk("t1_no_irq_without_valid", pulses, 0);
    retire(32'h100, 1'b0, 1'b0);
    chk("t1_interrupt", {31'b0, interrupt}, 1);
    chk("t1_flush", {31'b0, flush}, 1);
    chk("t1_trap_pc", trap_pc, 32'h100);
    step();
    chk("t1_interrupt_one_cycle", {31'b0, interrupt}, 0);
    chk("t1_flush_one_cycle", {31'b0, flush}, 0);
    chk("t1_in_handler", {31'b0, in_handler}, 1);
    chk("t1_trap_pc_hold", trap_pc, 32'h100);

    // 4: irq held in handler, retiring instructions (incl. WFI) -> no pulse
    pulses = 0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      retire(32'h1000 + 32'(i * 4), (i == 3), 1'b0);
      if (interrupt) pulses++;
      if (wfi_stall) highs++;
    end
    chk("t4_no_nested_pulse", pulses, 0);
    chk("t4_wfi_nop_in_handler", highs, 0);
    chk("t4_still_in_handler", {31'b0, in_handler}, 1);
    retire(32'h1028, 1'b0, 1'b1);
    chk("t4_mret_exit", {31'b0, in_handler}, 0);
    chk("t4_mret_no_irq", {31'b0, interrupt}, 0);
    retire(32'h104, 1'b0, 1'b0);
    chk("t4_retrap", {31'b0, interrupt}, 1);
    chk("t4_retrap_pc", trap_pc, 32'h104);
    step();
    set_irq(1'b0);
    retire(32'h1100, 1'b0, 1'b1);
    chk("t4_exit2", {31'b0, in_handler}, 0);

    // 2a: WFI, long wait, then wake with trap
    retire(32'h200, 1'b1, 1'b0);
    chk("t2_stall_first", {31'b0, wfi_stall}, 1);
    highs = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wfi_stall) highs++;
      if (interrupt) pulses++;
    end
    chk("t2_stall_held", highs, 20);
    chk("t2_no_irq_while_wait", pulses, 0);
    set_irq(1'b1);
    chk("t2_stall_until_irq", {31'b0, wfi_stall}, 1);
    step();
    chk("t2_wake_interrupt", {31'b0, interrupt}, 1);
    chk("t2_wake_trap_pc", trap_pc, 32'h200);
    chk("t2_wake_stall_drop", {31'b0, wfi_stall}, 0);
    step();
    set_irq(1'b0);
    retire(32'h1200, 1'b0, 1'b1);

    // 2b: WFI wake with MIE=0 -> resume, no trap
    mstatus_mie = 1'b0;
    retire(32'h240, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("t2b_stall", {31'b0, wfi_stall}, 1);
    set_irq(1'b1);
    step();
    chk("t2b_stall_drop", {31'b0, wfi_stall}, 0);
    chk("t2b_no_interrupt", {31'b0, interrupt}, 0);
    retire(32'h244, 1'b0, 1'b0);
    chk("t2b_mie0_no_trap", {31'b0, interrupt}, 0);
    chk("t2b_not_in_handler", {31'b0, in_handler}, 0);
    set_irq(1'b0);
    mstatus_mie = 1'b1;

    // 5: same-cycle WFI and trap -> trap wins
    set_irq(1'b1);
    retire(32'h300, 1'b1, 1'b0);
    chk("t5_interrupt", {31'b0, interrupt}, 1);
    chk("t5_trap_pc", trap_pc, 32'h300);
    chk("t5_no_stall", {31'b0, wfi_stall}, 0);
    step();
    chk("t5_no_stall2", {31'b0, wfi_stall}, 0);
    chk("t5_in_handler", {31'b0, in_handler}, 1);
    set_irq(1'b0);
    retire(32'h1300, 1'b0, 1'b1);

    // 3: WFI timeout of 8 on the second instance
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    retire(32'h400, 1'b1, 1'b0);
    chk("t3_stall_first", {31'b0, t_wfi_stall}, 1);
    highs = 1;
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (t_wfi_stall) highs++;
      if (t_interrupt) pulses++;
    end
    chk("t3_stall_cycles", highs, 8);
    chk("t3_no_interrupt", pulses, 0);
    chk("t3_no_timeout_default", {31'b0, wfi_stall}, 1);

    // Reset in WFI_WAIT drops wfi_stall at once
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_wfi_stall", {31'b0, wfi_stall}, 0);
    step();
    rst = 1'b1;
    step();

    // 6: reset during TRAP aborts pulse asynchronously
    set_irq(1'b1);
    retire(32'h500, 1'b0, 1'b0);
    chk("t6_pre_interrupt", {31'b0, interrupt}, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_interrupt", {31'b0, interrupt}, 0);
    chk("t6_rst_flush", {31'b0, flush}, 0);
    chk("t6_rst_in_handler", {31'b0, in_handler}, 0);
    chk("t6_rst_trap_pc", trap_pc, 0);
    ext_irq = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Interrupt latency from ext_irq rise with ex_valid held high
    ex_valid = 1'b1;
    ex_pc = 32'h600;
    ext_irq = 1'b1;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (interrupt && lat == 99) lat = i;
    end
    chk("t6_irq_latency", lat, 1 + SYNC_LAT);
    chk("t6_latency_trap_pc", trap_pc, 32'h600);
    idle_ex();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
